// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Stall/freeze/flush controller for the 5-stage pipeline, with
//            SRAM wait sequencing and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int MEM_TIMEOUT = 31,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 forward_en,
    input  logic [3:0]           ID_src_1,
    input  logic [3:0]           ID_src_2,
    input  logic                 ID_two_src,
    input  logic [3:0]           EXE_dest,
    input  logic                 EXE_wb_en,
    input  logic                 EXE_mem_r_en,
    input  logic [3:0]           MEM_dest,
    input  logic                 MEM_wb_en,
    input  logic                 mem_req,
    input  logic                 sram_ready,
    input  logic                 branch_taken,
    output logic                 hazard,
    output logic                 freeze_all,
    output logic                 flush,
    output logic                 mem_error,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] freeze_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int c_WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;

    logic w_m1, w_m2, w_n1, w_n2, w_raw;
    logic w_freeze;

    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_freeze_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    assign w_m1 = EXE_wb_en & (ID_src_1 == EXE_dest);
    assign w_m2 = ID_two_src & EXE_wb_en & (ID_src_2 == EXE_dest);
    assign w_n1 = MEM_wb_en & (ID_src_1 == MEM_dest);
    assign w_n2 = ID_two_src & MEM_wb_en & (ID_src_2 == MEM_dest);

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign w_raw = forward_en ? (EXE_mem_r_en & (w_m1 | w_m2))
                              : (w_m1 | w_m2 | w_n1 | w_n2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_freeze       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_freeze = mem_req & ~sram_ready;
                if (mem_req && !sram_ready) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = c_WAIT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                // mem_req is deliberately ignored here; only ready or timeout exits.
                w_freeze = ~sram_ready;
                if (sram_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == c_TIMEOUT) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_ONE;
                end
            end
            ST_ERR: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // A taken branch waits in EXE while frozen, so its flush lands on the first free cycle.
    assign freeze_all = w_freeze;
    assign flush      = branch_taken & ~w_freeze;
    assign hazard     = w_raw & ~branch_taken & ~w_freeze;
    assign mem_error  = (r_state == ST_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (hazard && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (freeze_all && (r_freeze_cnt != '1))
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
            if (flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign freeze_cnt = r_freeze_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Directed self-checking bench for pipeline_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int c_TIMEOUT = 31;
    localparam int c_CW      = 4;

    logic            clk;
    logic            rst;
    logic            forward_en;
    logic [3:0]      ID_src_1;
    logic [3:0]      ID_src_2;
    logic            ID_two_src;
    logic [3:0]      EXE_dest;
    logic            EXE_wb_en;
    logic            EXE_mem_r_en;
    logic [3:0]      MEM_dest;
    logic            MEM_wb_en;
    logic            mem_req;
    logic            sram_ready;
    logic            branch_taken;
    logic            hazard;
    logic            freeze_all;
    logic            flush;
    logic            mem_error;
    logic [c_CW-1:0] stall_cnt;
    logic [c_CW-1:0] freeze_cnt;
    logic [c_CW-1:0] flush_cnt;

    int n_cmp;
    int n_fail;

    pipeline_sequencer #(
        .MEM_TIMEOUT (c_TIMEOUT),
        .CNT_WIDTH   (c_CW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .forward_en   (forward_en),
        .ID_src_1     (ID_src_1),
        .ID_src_2     (ID_src_2),
        .ID_two_src   (ID_two_src),
        .EXE_dest     (EXE_dest),
        .EXE_wb_en    (EXE_wb_en),
        .EXE_mem_r_en (EXE_mem_r_en),
        .MEM_dest     (MEM_dest),
        .MEM_wb_en    (MEM_wb_en),
        .mem_req      (mem_req),
        .sram_ready   (sram_ready),
        .branch_taken (branch_taken),
        .hazard       (hazard),
        .freeze_all   (freeze_all),
        .flush        (flush),
        .mem_error    (mem_error),
        .stall_cnt    (stall_cnt),
        .freeze_cnt   (freeze_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic h, input logic fr, input logic fl,
                           input logic me);
        chk({tag, ".hazard"}, 32'(hazard), 32'(h));
        chk({tag, ".freeze_all"}, 32'(freeze_all), 32'(fr));
        chk({tag, ".flush"}, 32'(flush), 32'(fl));
        chk({tag, ".mem_error"}, 32'(mem_error), 32'(me));
    endtask

    task automatic chk_cnt(input string tag, input int s, input int fz, input int fl);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(s));
        chk({tag, ".freeze_cnt"}, 32'(freeze_cnt), 32'(fz));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(fl));
    endtask

    task automatic clear_inputs();
        forward_en   = 1'b0;
        ID_src_1     = 4'd0;
        ID_src_2     = 4'd0;
        ID_two_src   = 1'b0;
        EXE_dest     = 4'd0;
        EXE_wb_en    = 1'b0;
        EXE_mem_r_en = 1'b0;
        MEM_dest     = 4'd0;
        MEM_wb_en    = 1'b0;
        mem_req      = 1'b0;
        sram_ready   = 1'b0;
        branch_taken = 1'b0;
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        clear_inputs();
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 0, 0, 0);
        rst = 1'b1;

        // Idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk_cnt("idle", 0, 0, 0);

        // RAW without forwarding: EXE match on src1
        ID_src_1 = 4'd3; EXE_dest = 4'd3; EXE_wb_en = 1'b1;
        #1 chk("raw_exe.hazard", 32'(hazard), 32'd1);
        tick();
        chk("raw_exe.stall_cnt", 32'(stall_cnt), 32'd1);

        // MEM match on src2 but src2 not used
        EXE_wb_en = 1'b0; ID_src_2 = 4'd5; MEM_dest = 4'd5; MEM_wb_en = 1'b1;
        #1 chk("raw_mem_one_src.hazard", 32'(hazard), 32'd0);
        tick();
        chk("raw_mem_one_src.stall_cnt", 32'(stall_cnt), 32'd1);

        // Same, src2 used
        ID_two_src = 1'b1;
        #1 chk("raw_mem_two_src.hazard", 32'(hazard), 32'd1);
        tick();
        chk("raw_mem_two_src.stall_cnt", 32'(stall_cnt), 32'd2);

        // Forwarding on: MEM match is bypassed
        forward_en = 1'b1;
        #1 chk("fwd_mem.hazard", 32'(hazard), 32'd0);

        // Load-use with forwarding
        clear_inputs();
        forward_en = 1'b1; EXE_mem_r_en = 1'b1; EXE_wb_en = 1'b1;
        EXE_dest = 4'd4; ID_src_1 = 4'd4;
        #1 chk("load_use.hazard", 32'(hazard), 32'd1);
        tick();
        chk("load_use.stall_cnt", 32'(stall_cnt), 32'd3);
        EXE_mem_r_en = 1'b0;
        #1 chk("alu_fwd.hazard", 32'(hazard), 32'd0);
        tick();
        chk("alu_fwd.stall_cnt", 32'(stall_cnt), 32'd3);

        // SRAM wait: ready in 4th cycle
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("sram_wait.freeze_all", 32'(freeze_all), 32'd1);
            tick();
        end
        sram_ready = 1'b1;
        #1 chk("sram_ready.freeze_all", 32'(freeze_all), 32'd0);
        tick();
        sram_ready = 1'b0; mem_req = 1'b0;
        #1 chk("sram_done.freeze_all", 32'(freeze_all), 32'd0);
        chk_cnt("sram_done", 3, 3, 0);

        // Branch (with a pending RAW) during freeze
        forward_en = 1'b0; ID_src_1 = 4'd3; EXE_dest = 4'd3; EXE_wb_en = 1'b1;
        mem_req = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk_out("br_frozen", 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        sram_ready = 1'b1;
        #1 chk_out("br_release", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        clear_inputs();
        #1 chk_out("br_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("br_after", 3, 5, 1);

        // Timeout into the error trap; freeze_cnt saturates at 15
        mem_req = 1'b1;
        for (int i = 0; i < c_TIMEOUT; i++) tick();
        chk_out("timeout_edge", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("err", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_cnt("err_sat", 3, 15, 1);
        mem_req = 1'b0; branch_taken = 1'b1;
        #1 chk_out("err_stuck", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_cnt("err_stuck", 3, 15, 1);

        // Asynchronous reset mid-cycle
        branch_taken = 1'b0;
        #2 rst = 1'b0;
        #1 chk_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("async_rst", 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("post_rst", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central stall/flush controller for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Detects RAW data hazards between the ID-stage operands and the EXE/MEM destinations, and drives `hazard` into the ID stage.
- Sequences multi-cycle SRAM accesses by freezing the whole pipeline until the memory handshake completes, and issues branch flushes.
- Keeps saturating performance counters for stall, freeze and flush cycles.

Parameters:
- MEM_TIMEOUT, 31: maximum MEM_WAIT cycles without `sram_ready` before the error trap.
- CNT_WIDTH, 16: width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- forward_en  in  1  forwarding unit enabled.
- ID_src_1  in  4  Rn index of the instruction in ID.
- ID_src_2  in  4  second source index (Rm, or Rd for stores).
- ID_two_src  in  1  ID instruction reads ID_src_2.
- EXE_dest  in  4  destination index in EXE.
- EXE_wb_en  in  1  EXE instruction writes back.
- EXE_mem_r_en  in  1  EXE instruction is a load.
- MEM_dest  in  4  destination index in MEM.
- MEM_wb_en  in  1  MEM instruction writes back.
- mem_req  in  1  MEM-stage instruction needs SRAM (read or write).
- sram_ready  in  1  SRAM controller completion, held 1 cycle.
- branch_taken  in  1  EXE-stage branch resolved taken.
- hazard  out  1  stall IF/PC and ID, insert bubble into ID/EXE.
- freeze_all  out  1  hold every pipeline register and PC.
- flush  out  1  clear IF/ID and ID/EXE registers.
- mem_error  out  1  sticky SRAM timeout flag.
- stall_cnt  out  CNT_WIDTH  cycles with hazard=1.
- freeze_cnt  out  CNT_WIDTH  cycles with freeze_all=1.
- flush_cnt  out  CNT_WIDTH  cycles with flush=1.

Behaviour:

Reset (rst=0, async):
- State goes to RUN; wait_cnt=0.
- mem_error=0; all counters=0.
- Combinational outputs evaluate with state=RUN.
- Reset mid-MEM_WAIT or in ERR returns to RUN immediately.

Raw hazard (combinational):
- m1 = EXE_wb_en & (ID_src_1==EXE_dest).
- m2 = ID_two_src & EXE_wb_en & (ID_src_2==EXE_dest).
- n1 = MEM_wb_en & (ID_src_1==MEM_dest).
- n2 = ID_two_src & MEM_wb_en & (ID_src_2==MEM_dest).
- forward_en=0: raw = m1|m2|n1|n2.
- forward_en=1: raw = EXE_mem_r_en & (m1|m2), i.e. load-use only.

Output priority, combinational from state and inputs:
- freeze_all, then flush, then hazard.
- hazard = raw & ~branch_taken & ~freeze_all.
- flush = branch_taken & ~freeze_all. The branch stays in EXE while frozen, so the flush occurs on the first unfrozen cycle.

FSM:
- RUN:
  - freeze_all = mem_req & ~sram_ready.
  - mem_req & ~sram_ready: go to MEM_WAIT, wait_cnt=1.
  - mem_req & sram_ready (single-cycle access): stay in RUN, no freeze.
- MEM_WAIT:
  - freeze_all = ~sram_ready.
  - sram_ready=1: go to RUN, wait_cnt=0. Pipeline advances in that same cycle.
  - Else if wait_cnt==MEM_TIMEOUT: go to ERR.
  - Else wait_cnt+1.
  - mem_req dropping in MEM_WAIT is ignored; only sram_ready or timeout exits.
- ERR:
  - freeze_all=1, mem_error=1.
  - Leave only via reset.

Counters:
- Each increments on a rising edge when its output was 1 in that cycle.
- Saturate at 2^CNT_WIDTH-1; no wrap.
- Frozen cycles increment only freeze_cnt.

wait_cnt is ceil(log2(MEM_TIMEOUT+1)) bits.

Test Plan:
- Reset then idle: all inputs 0 → hazard=freeze_all=flush=mem_error=0, counters stay 0 for 10 cycles.
- RAW without forwarding: forward_en=0, ID_src_1=3, EXE_dest=3, EXE_wb_en=1 → hazard=1, stall_cnt=1 after the edge. Repeat with ID_src_2=5, MEM_dest=5, MEM_wb_en=1, ID_two_src=0 → hazard=0.
- Load-use with forwarding: forward_en=1, EXE_mem_r_en=1, EXE_dest=4, ID_src_1=4 → hazard=1. Same case with EXE_mem_r_en=0 → hazard=0.
- SRAM wait: mem_req=1, sram_ready asserted on the 4th cycle → freeze_all=1 for exactly 3 cycles, 0 in the ready cycle, freeze_cnt=3, state back in RUN.
- Branch during freeze: branch_taken=1 while frozen → flush=0 and hazard=0 until sram_ready, then flush=1 for one cycle, flush_cnt=1.
- Timeout and reset: mem_req=1, sram_ready=0 for MEM_TIMEOUT+2 cycles → mem_error=1 and freeze_all=1 stuck. Pulse rst=0 asynchronously mid-cycle → all outputs and counters 0 immediately.
